data_mem_be: RTL and testbench

DATA_MEM_BE -- requirements
Module: data_mem_be

---
 rtl/data_mem_pkg.sv | 35 +++
 rtl/data_mem_be_lane_extract.sv | 31 +++
 rtl/data_mem_be.sv | 148 ++++++++++++++
 tb/tb_data_mem_be.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the byte-enabled data memory.
`default_nettype none

package data_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    is_legal = 1'b1;
      SZ_H:    is_legal = ~off[0];
      SZ_W:    is_legal = (off == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << off;
      SZ_H:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_be_lane_extract.sv
// Combinational load extraction: selects the addressed byte/half/word and extends it.
`default_nettype none

module lane_extract
  import data_mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    bsel   = raw[8*off +: 8];
    hsel   = off[1] ? raw[31:16] : raw[15:0];
    result = '0;
    case (size)
      SZ_B:    result = uns ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
      SZ_H:    result = uns ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
      SZ_W:    result = raw;
      default: result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_be.sv
// Byte-enabled 32-bit data memory with zero-fill FSM, aligned-access checking
// and extended loads delivered one cycle after acceptance.
`default_nettype none

module data_mem_be
  import data_mem_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter bit INIT_CLR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              clr,
  input  logic [1:0]        dbg_sel,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              misalign,
  output logic [7:0]        dbg_led
);

  localparam int DEPTH = 2**ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       ram_q;

  logic              accept, legal, rd_en;
  logic [ADDR_W-1:0] mem_idx;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;

  logic              ld_pend_q, ill_ld_q, misalign_q;
  logic [1:0]        off_q, size_q;
  logic              uns_q;
  logic [31:0]       rdata_hold_q, raw_cap_q, ext, raw_word;

  assign ready  = (state_q == ST_IDLE) & ~clr;
  assign accept = req & ready;
  assign legal  = is_legal(size, addr[1:0]);
  assign rd_en  = accept & ~we & legal;

  always_comb begin
    mem_idx = addr[ADDR_W+1:2];
    wr_be   = 4'b0000;
    wr_data = '0;
    if (state_q == ST_INIT) begin
      mem_idx = cnt_q;
      wr_be   = 4'b1111;
    end else if (accept & we & legal) begin
      wr_be = lane_mask(size, addr[1:0]);
      case (size)
        SZ_B:    wr_data = {4{wdata[7:0]}};
        SZ_H:    wr_data = {2{wdata[15:0]}};
        default: wr_data = wdata;
      endcase
    end
  end

  // Single port, per-byte write enables, registered read: maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) mem[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
    if (rd_en) ram_q <= mem[mem_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_CLR ? ST_INIT : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        if (clr) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_pend_q    <= 1'b0;
      ill_ld_q     <= 1'b0;
      misalign_q   <= 1'b0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      rdata_hold_q <= '0;
      raw_cap_q    <= '0;
    end else begin
      ld_pend_q  <= rd_en;
      ill_ld_q   <= accept & ~we & ~legal;
      misalign_q <= accept & ~legal;
      if (rd_en) begin
        off_q  <= addr[1:0];
        size_q <= size;
        uns_q  <= uns;
      end
      if (rvalid)    rdata_hold_q <= rdata;
      if (ld_pend_q) raw_cap_q    <= ram_q;
    end
  end

  lane_extract u_lane_extract (
    .raw    (ram_q),
    .off    (off_q),
    .size   (size_q),
    .uns    (uns_q),
    .result (ext)
  );

  // The RAM output register is only meaningful in the cycle after a legal load;
  // afterwards the held copies keep rdata and dbg_led stable.
  assign rvalid   = ld_pend_q | ill_ld_q;
  assign misalign = misalign_q;
  assign rdata    = !rvalid ? rdata_hold_q : (ld_pend_q ? ext : 32'h0);
  assign raw_word = ld_pend_q ? ram_q : raw_cap_q;
  assign dbg_led  = raw_word[8*dbg_sel +: 8];

endmodule

`default_nettype wire

// File: tb/tb_data_mem_be.sv
// Directed self-checking bench for data_mem_be with hand-computed expectations.
`default_nettype none

module tb_data_mem_be;

  localparam int ADDR_W = 6;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10;

  logic              clk = 1'b0;
  logic              rst_n, req, we, uns, clr;
  logic [1:0]        size, dbg_sel;
  logic [ADDR_W+1:0] addr;
  logic [31:0]       wdata, rdata;
  logic              ready, rvalid, misalign;
  logic [7:0]        dbg_led;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  always #5 clk = ~clk;

  data_mem_be #(.ADDR_W(ADDR_W), .INIT_CLR(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .size     (size),
    .uns      (uns),
    .addr     (addr),
    .wdata    (wdata),
    .clr      (clr),
    .dbg_sel  (dbg_sel),
    .ready    (ready),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .misalign (misalign),
    .dbg_led  (dbg_led)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One request cycle; returns #1 after the accepting edge, where the response is visible.
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [7:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; uns = 1'b0; clr = 1'b0;
    size = W; dbg_sel = 2'd0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",    {31'h0, ready},    32'h0);
    check("rst_rvalid",   {31'h0, rvalid},   32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    check("rst_rdata",    rdata,             32'h0);
    check("rst_dbg",      {24'h0, dbg_led},  32'h0);
    rst_n = 1'b1;
    wait_ready(n);
    check("init_len", n, 64);

    access(1'b0, W, 1'b0, 8'h00, 32'h0);
    check("ld0_rvalid", {31'h0, rvalid}, 32'h1);
    check("ld0_rdata",  rdata,           32'h0);
    access(1'b0, W, 1'b0, 8'hFC, 32'h0);
    check("ldlast_rdata", rdata, 32'h0);

    access(1'b1, W, 1'b0, 8'h04, 32'h1111_2222);
    check("st_norvalid", {31'h0, rvalid}, 32'h0);
    access(1'b1, B, 1'b0, 8'h05, 32'hFFFF_FFAB);
    access(1'b0, W, 1'b0, 8'h04, 32'h0);
    check("merge_rvalid", {31'h0, rvalid}, 32'h1);
    check("merge_rdata",  rdata,           32'h1111_AB22);
    idle_cycle();
    check("hold_rvalid", {31'h0, rvalid}, 32'h0);
    check("hold_rdata",  rdata,           32'h1111_AB22);

    access(1'b1, W, 1'b0, 8'h08, 32'h8000_80F0);
    access(1'b0, B, 1'b0, 8'h08, 32'h0);
    check("lb_s",  rdata, 32'hFFFF_FFF0);
    access(1'b0, B, 1'b1, 8'h08, 32'h0);
    check("lb_u",  rdata, 32'h0000_00F0);
    access(1'b0, H, 1'b0, 8'h0A, 32'h0);
    check("lh_s",  rdata, 32'hFFFF_8000);
    access(1'b0, H, 1'b1, 8'h0A, 32'h0);
    check("lh_u",  rdata, 32'h0000_8000);
    access(1'b0, B, 1'b0, 8'h09, 32'h0);
    check("lb1_s", rdata, 32'hFFFF_FF80);
    check("lb1_mis", {31'h0, misalign}, 32'h0);

    access(1'b1, W, 1'b0, 8'h0C, 32'h5555_AAAA);
    access(1'b1, H, 1'b0, 8'h0D, 32'h0000_DEAD);
    check("sth_mis",    {31'h0, misalign}, 32'h1);
    check("sth_rvalid", {31'h0, rvalid},   32'h0);
    idle_cycle();
    check("mis_pulse", {31'h0, misalign}, 32'h0);
    access(1'b0, W, 1'b0, 8'h0C, 32'h0);
    check("unchanged", rdata, 32'h5555_AAAA);
    access(1'b0, W, 1'b0, 8'h0E, 32'h0);
    check("lw_mis",    {31'h0, misalign}, 32'h1);
    check("lw_rvalid", {31'h0, rvalid},   32'h1);
    check("lw_rdata",  rdata,             32'h0);
    access(1'b0, 2'b11, 1'b0, 8'h10, 32'h0);
    check("sz11_mis",  {31'h0, misalign}, 32'h1);

    access(1'b1, W, 1'b0, 8'h10, 32'h3333_6666);
    access(1'b0, W, 1'b0, 8'h10, 32'h0);
    idle_cycle();
    for (int s = 0; s < 4; s++) begin
      dbg_sel = 2'(s);
      #1;
      check($sformatf("dbg%0d", s), {24'h0, dbg_led}, (s < 2) ? 32'h66 : 32'h33);
    end

    access(1'b0, W, 1'b0, 8'h04, 32'h0);
    clr = 1'b1;
    #1;
    check("clr_rvalid", {31'h0, rvalid}, 32'h1);
    check("clr_rdata",  rdata,           32'h1111_AB22);
    check("clr_ready",  {31'h0, ready},  32'h0);
    @(posedge clk); #1;
    clr = 1'b0;
    wait_ready(n);
    check("clr_init_len", n, 64);
    access(1'b0, W, 1'b0, 8'h04, 32'h0);
    check("clr_w04", rdata, 32'h0);
    access(1'b0, W, 1'b0, 8'h10, 32'h0);
    check("clr_w10", rdata, 32'h0);

    access(1'b1, W, 1'b0, 8'h20, 32'hCAFE_F00D);
    access(1'b0, W, 1'b0, 8'h20, 32'h0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'h0, ready},   32'h0);
    check("mid_rst_dbg",   {24'h0, dbg_led}, 32'h0);
    check("mid_rst_rdata", rdata,            32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready(n);
    check("rst_init_len", n, 64);
    access(1'b0, W, 1'b0, 8'h20, 32'h0);
    check("rst_w20", rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
